// File: rtl/pixel_stream_transmitter.sv
// Buffers one packed binary frame and streams it to the input layer one pixel per clock.
// Optional macro TX_DOUBLE_BUFFER_EN adds a shadow buffer so the next frame loads during SEND.
module pixel_stream_transmitter #(
  parameter int INPUT_LAYER_NODES = 10,
  parameter int WORD_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] wordIn,
  input  logic                  wordValid,
  output logic                  wordReady,
  input  logic                  readyForInputs,
  output logic                  inputsInbound,
  output logic                  pixelValue,
  output logic                  busy,
  output logic                  frameSent
);
  localparam int N     = INPUT_LAYER_NODES;
  localparam int W     = WORD_WIDTH;
  localparam int WORDS = (N + W - 1) / W;
  localparam int PCW   = (N > 1) ? $clog2(N) : 1;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_READY, SEND, DONE} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [N-1:0]   frame_q, frame_d;
  logic           ready_q, ready_d;
  logic           inbound_q, inbound_d;
  logic           pixel_q, pixel_d;
  logic           busy_q, busy_d;
  logic           sent_q, sent_d;
  logic           accept;

  assign accept = wordValid & ready_q;

`ifdef TX_DOUBLE_BUFFER_EN
  logic [N-1:0]   shadow_q, shadow_d, shadow_n;
  logic [WCW-1:0] swcnt_q, swcnt_d, swcnt_n;
  logic           sfull_q, sfull_d, sfull_n;

  // Words arriving outside IDLE/LOAD are collected in the shadow buffer.
  always_comb begin
    shadow_n = shadow_q;
    swcnt_n  = swcnt_q;
    sfull_n  = sfull_q;
    if (accept && state_q != IDLE && state_q != LOAD) begin
      for (int k = 0; k < N; k++)
        if (swcnt_q == WCW'(k / W)) shadow_n[k] = wordIn[k % W];
      if (swcnt_q == WCW'(WORDS - 1)) begin
        swcnt_n = '0;
        sfull_n = 1'b1;
      end else begin
        swcnt_n = swcnt_q + WCW'(1);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    frame_d   = frame_q;
    inbound_d = 1'b0;
    pixel_d   = 1'b0;
    sent_d    = 1'b0;
`ifdef TX_DOUBLE_BUFFER_EN
    shadow_d  = shadow_n;
    swcnt_d   = swcnt_n;
    sfull_d   = sfull_n;
`endif
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          for (int k = 0; k < N; k++)
            if (wcnt_q == WCW'(k / W)) frame_d[k] = wordIn[k % W];
          if (wcnt_q == WCW'(WORDS - 1)) begin
            wcnt_d  = '0;
            state_d = WAIT_READY;
          end else begin
            wcnt_d  = wcnt_q + WCW'(1);
            state_d = LOAD;
          end
        end
      end
      WAIT_READY: begin
        if (readyForInputs) begin
          state_d   = SEND;
          pcnt_d    = '0;
          inbound_d = 1'b1;
          pixel_d   = frame_q[0];
        end
      end
      SEND: begin
        if (pcnt_q == PCW'(N - 1)) begin
          state_d = DONE;
          pcnt_d  = '0;
          sent_d  = 1'b1;
        end else begin
          pcnt_d    = pcnt_q + PCW'(1);
          inbound_d = 1'b1;
          pixel_d   = frame_q[pcnt_d];
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef TX_DOUBLE_BUFFER_EN
        if (sfull_n) begin
          frame_d = shadow_n;
          sfull_d = 1'b0;
          swcnt_d = '0;
          // Sampling readyForInputs here keeps the gap between frames at the single DONE cycle.
          if (readyForInputs) begin
            state_d   = SEND;
            pcnt_d    = '0;
            inbound_d = 1'b1;
            pixel_d   = shadow_n[0];
          end else begin
            state_d = WAIT_READY;
          end
        end else if (swcnt_n != '0) begin
          frame_d = shadow_n;
          wcnt_d  = swcnt_n;
          swcnt_d = '0;
          state_d = LOAD;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == LOAD);
`ifdef TX_DOUBLE_BUFFER_EN
    ready_d = ready_d || !sfull_d;
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      frame_q   <= '0;
      ready_q   <= 1'b0;
      inbound_q <= 1'b0;
      pixel_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
`ifdef TX_DOUBLE_BUFFER_EN
      shadow_q  <= '0;
      swcnt_q   <= '0;
      sfull_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      frame_q   <= frame_d;
      ready_q   <= ready_d;
      inbound_q <= inbound_d;
      pixel_q   <= pixel_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
`ifdef TX_DOUBLE_BUFFER_EN
      shadow_q  <= shadow_d;
      swcnt_q   <= swcnt_d;
      sfull_q   <= sfull_d;
`endif
    end
  end

  assign wordReady     = ready_q;
  assign inputsInbound = inbound_q;
  assign pixelValue    = pixel_q;
  assign busy          = busy_q;
  assign frameSent     = sent_q;

endmodule

// File: tb/tb_pixel_stream_transmitter.sv
// Scoreboard bench for pixel_stream_transmitter: expected pixels queued at load, popped while inbound.
module tb_pixel_stream_transmitter;
  localparam int N = 10;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] wordIn = '0;
  logic         wordValid = 1'b0;
  logic         readyForInputs = 1'b0;
  logic         wordReady, inputsInbound, pixelValue, busy, frameSent;

  int   total = 0;
  int   bad = 0;
  logic exp_q[$];

  pixel_stream_transmitter #(.INPUT_LAYER_NODES(N), .WORD_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .wordIn        (wordIn),
    .wordValid     (wordValid),
    .wordReady     (wordReady),
    .readyForInputs(readyForInputs),
    .inputsInbound (inputsInbound),
    .pixelValue    (pixelValue),
    .busy          (busy),
    .frameSent     (frameSent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && inputsInbound) begin
      if (exp_q.size() == 0) check("stray_pixel", exp_q.size(), 1);
      else check("pixel", {31'd0, pixelValue}, {31'd0, exp_q.pop_front()});
    end
  end

  task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] f;
    f = {w1, w0};
    for (int i = 0; i < N; i++) exp_q.push_back(f[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    wordIn    = w;
    wordValid = 1'b1;
    while (!wordReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("word_accept_timeout", n, 0);
    @(posedge clk);
    #1;
    wordValid = 1'b0;
  endtask

  task automatic run_frame(input int drop_at);
    int cnt;
    cnt = 0;
    @(negedge clk);
    readyForInputs = 1'b1;
    @(negedge clk);
    check("first_pixel_latency", inputsInbound, 1);
    while (inputsInbound && cnt < 40) begin
      cnt++;
`ifndef TX_DOUBLE_BUFFER_EN
      check("word_ready_in_send", wordReady, 0);
`endif
      if (cnt == drop_at) begin
        readyForInputs = 1'b0;
`ifndef TX_DOUBLE_BUFFER_EN
        wordValid = 1'b1;
        wordIn    = 8'hFF;
`endif
      end
      @(negedge clk);
    end
    wordValid      = 1'b0;
    readyForInputs = 1'b0;
    check("inbound_len", cnt, N);
    check("frame_sent", frameSent, 1);
    check("done_pixel", pixelValue, 0);
    @(negedge clk);
    check("frame_sent_pulse", frameSent, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word_ready", wordReady, 0);
    check("rst_inbound", inputsInbound, 0);
    check("rst_pixel", pixelValue, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_sent", frameSent, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_word_ready", wordReady, 1);
    check("idle_busy0", busy, 0);

    // basic frame 0xB4, 0x02
    send_word(8'hB4);
    send_word(8'h02);
    push_frame(8'hB4, 8'h02);
    run_frame(-1);

    // long wait in WAIT_READY
    send_word(8'h35);
    send_word(8'h03);
    push_frame(8'h35, 8'h03);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("wait_inbound", inputsInbound, 0);
      check("wait_busy", busy, 1);
`ifndef TX_DOUBLE_BUFFER_EN
      check("wait_word_ready", wordReady, 0);
`endif
    end
    run_frame(-1);

    // readyForInputs dropped mid-frame, junk words offered during SEND
    send_word(8'h5A);
    send_word(8'h01);
    push_frame(8'h5A, 8'h01);
    run_frame(4);

    // junk upper bits in last word
    send_word(8'hDB);
    send_word(8'hFC);
    push_frame(8'hDB, 8'hFC);
    run_frame(-1);

    // reset in the middle of SEND
    send_word(8'hFF);
    send_word(8'h03);
    push_frame(8'hFF, 8'h03);
    @(negedge clk);
    readyForInputs = 1'b1;
    cnt = 0;
    while (!inputsInbound && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) check("send_start_timeout", cnt, 0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_inbound", inputsInbound, 0);
    check("midrst_pixel", pixelValue, 0);
    check("midrst_busy", busy, 0);
    check("midrst_word_ready", wordReady, 0);
    check("midrst_frame_sent", frameSent, 0);
    exp_q.delete();
    readyForInputs = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_word_ready", wordReady, 1);
    send_word(8'hB4);
    send_word(8'h02);
    push_frame(8'hB4, 8'h02);
    run_frame(-1);

`ifdef TX_DOUBLE_BUFFER_EN
    // second frame loaded during the first SEND, back-to-back transfer
    send_word(8'hB4);
    send_word(8'h02);
    push_frame(8'hB4, 8'h02);
    push_frame(8'hDB, 8'hFC);
    @(negedge clk);
    readyForInputs = 1'b1;
    @(negedge clk);
    check("db_first_latency", inputsInbound, 1);
    cnt = 0;
    while (inputsInbound && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        check("db_ready_in_send", wordReady, 1);
        wordValid = 1'b1;
        wordIn    = 8'hDB;
      end
      if (cnt == 3) wordIn = 8'hFC;
      if (cnt == 4) wordValid = 1'b0;
      @(negedge clk);
    end
    check("db_len1", cnt, N);
    check("db_sent1", frameSent, 1);
    check("db_busy_gap", busy, 1);
    @(negedge clk);
    check("db_one_gap", inputsInbound, 1);
    cnt = 0;
    while (inputsInbound && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    readyForInputs = 1'b0;
    check("db_len2", cnt, N);
    check("db_sent2", frameSent, 1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
